// File: rtl/mips_hazard_scoreboard_if.sv
// ID-stage <-> scoreboard signal bundle: instruction operand/destination info in,
// interlock decision and scoreboard status out.
interface mips_hazard_scoreboard_if #(
   parameter int REG_AW = 5,
   parameter int CNT_W  = 16
);
   logic                   id_valid;
   logic [REG_AW-1:0]      id_rs;
   logic [REG_AW-1:0]      id_rt;
   logic                   id_rs_used;
   logic                   id_rt_used;
   logic [REG_AW-1:0]      id_rd;
   logic                   id_wr_en;
   logic                   id_is_load;
   logic                   flush;
   logic                   stall;
   logic                   issue;
   logic [2**REG_AW-1:0]   busy_vec;
   logic [CNT_W-1:0]       stall_cnt;

   modport master (
      output id_valid, id_rs, id_rt, id_rs_used, id_rt_used, id_rd, id_wr_en, id_is_load, flush,
      input  stall, issue, busy_vec, stall_cnt
   );

   modport slave (
      input  id_valid, id_rs, id_rt, id_rs_used, id_rt_used, id_rd, id_wr_en, id_is_load, flush,
      output stall, issue, busy_vec, stall_cnt
   );
endinterface

// File: rtl/mips_hazard_scoreboard.sv
// Register scoreboard and ID-stage interlock for the pipelined MIPS32 core: a countdown
// per register marks it pending until its result is readable, and ID stalls on a pending source.
module mips_hazard_scoreboard #(
   parameter int REG_AW   = 5,
   parameter int WB_LAT   = 3,
   parameter int LOAD_LAT = 1,
   parameter int FWD_EN   = 0,
   parameter int CNT_W    = 16
) (
   input  logic                     clk1,
   input  logic                     rst_n,
   mips_hazard_scoreboard_if.slave  sb
);
   localparam int NREGS   = 2**REG_AW;
   localparam int MAX_LAT = (WB_LAT > LOAD_LAT) ? WB_LAT : LOAD_LAT;
   localparam int CW      = $clog2(MAX_LAT + 1);

   typedef logic [CW-1:0] cnt_t;

   cnt_t              cnt [NREGS];
   logic [NREGS-1:0]  busy;
   logic              haz;
   logic              set_en;
   cnt_t              set_val;
   logic [CNT_W-1:0]  stall_cnt_q;

   function automatic cnt_t dec_floor(input cnt_t c);
      return (c == '0) ? c : c - cnt_t'(1);
   endfunction

   function automatic cnt_t max_cnt(input cnt_t a, input cnt_t b);
      return (a > b) ? a : b;
   endfunction

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
      return (&c) ? c : c + CNT_W'(1);
   endfunction

   always_comb begin
      busy = '0;
      for (int r = 0; r < NREGS; r++) busy[r] = (cnt[r] != '0);
   end

   assign haz          = (sb.id_rs_used & busy[sb.id_rs]) | (sb.id_rt_used & busy[sb.id_rt]);
   assign sb.stall     = sb.id_valid & ~sb.flush & haz;
   assign sb.issue     = sb.id_valid & ~sb.flush & ~haz;
   assign sb.busy_vec  = busy;
   assign sb.stall_cnt = stall_cnt_q;

   // With forwarding only loads open a window; otherwise every register write does.
   always_comb begin
      set_en  = 1'b0;
      set_val = '0;
      if (sb.issue && sb.id_wr_en && sb.id_rd != '0) begin
         if (FWD_EN == 0) begin
            set_en  = 1'b1;
            set_val = cnt_t'(WB_LAT);
         end else if (sb.id_is_load) begin
            set_en  = 1'b1;
            set_val = cnt_t'(LOAD_LAT);
         end
      end
   end

   // A new write never shortens an older pending window (WAW keeps the longer one).
   always_ff @(posedge clk1 or negedge rst_n) begin
      if (!rst_n) begin
         for (int r = 0; r < NREGS; r++) cnt[r] <= '0;
      end else begin
         cnt[0] <= '0;
         for (int r = 1; r < NREGS; r++) begin
            if (set_en && sb.id_rd == REG_AW'(r)) cnt[r] <= max_cnt(set_val, dec_floor(cnt[r]));
            else                                  cnt[r] <= dec_floor(cnt[r]);
         end
      end
   end

   always_ff @(posedge clk1 or negedge rst_n) begin
      if (!rst_n)        stall_cnt_q <= '0;
      else if (sb.stall) stall_cnt_q <= sat_inc(stall_cnt_q);
   end
endmodule

// File: tb/tb_mips_hazard_scoreboard.sv
// Bench for mips_hazard_scoreboard: three builds (no forwarding, forwarding, 4-bit stall counter)
// driven by one stimulus stream, checked by vector tables, directed sequences and a timestamp model.
module tb_mips_hazard_scoreboard;
   logic clk1;
   logic rst_n;
   logic       in_valid, in_rsu, in_rtu, in_we, in_ld, in_fl;
   logic [4:0] in_rs, in_rt, in_rd;

   int n_cmp  = 0;
   int n_fail = 0;

   mips_hazard_scoreboard_if #(.REG_AW(5), .CNT_W(16)) if0 ();
   mips_hazard_scoreboard_if #(.REG_AW(5), .CNT_W(16)) if1 ();
   mips_hazard_scoreboard_if #(.REG_AW(5), .CNT_W(4))  if2 ();

   assign if0.id_valid = in_valid;   assign if1.id_valid = in_valid;   assign if2.id_valid = in_valid;
   assign if0.id_rs = in_rs;         assign if1.id_rs = in_rs;         assign if2.id_rs = in_rs;
   assign if0.id_rt = in_rt;         assign if1.id_rt = in_rt;         assign if2.id_rt = in_rt;
   assign if0.id_rs_used = in_rsu;   assign if1.id_rs_used = in_rsu;   assign if2.id_rs_used = in_rsu;
   assign if0.id_rt_used = in_rtu;   assign if1.id_rt_used = in_rtu;   assign if2.id_rt_used = in_rtu;
   assign if0.id_rd = in_rd;         assign if1.id_rd = in_rd;         assign if2.id_rd = in_rd;
   assign if0.id_wr_en = in_we;      assign if1.id_wr_en = in_we;      assign if2.id_wr_en = in_we;
   assign if0.id_is_load = in_ld;    assign if1.id_is_load = in_ld;    assign if2.id_is_load = in_ld;
   assign if0.flush = in_fl;         assign if1.flush = in_fl;         assign if2.flush = in_fl;

   mips_hazard_scoreboard #(.REG_AW(5), .WB_LAT(3), .LOAD_LAT(1), .FWD_EN(0), .CNT_W(16))
      u_dut (.clk1(clk1), .rst_n(rst_n), .sb(if0));
   mips_hazard_scoreboard #(.REG_AW(5), .WB_LAT(3), .LOAD_LAT(1), .FWD_EN(1), .CNT_W(16))
      u_fwd (.clk1(clk1), .rst_n(rst_n), .sb(if1));
   mips_hazard_scoreboard #(.REG_AW(5), .WB_LAT(3), .LOAD_LAT(1), .FWD_EN(0), .CNT_W(4))
      u_sat (.clk1(clk1), .rst_n(rst_n), .sb(if2));

   initial begin
      clk1 = 1'b0;
      forever #5 clk1 = ~clk1;
   end

   // Reference model: register r of build f is readable from cycle rdy[f][r] onward.
   int cyc = 0;
   int rdy [2][32];
   int sc  [2];

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   function automatic bit m_busy(int f, int r);
      return (r != 0) && (rdy[f][r] > cyc);
   endfunction

   function automatic bit m_haz(int f);
      return (in_rsu && m_busy(f, in_rs)) || (in_rtu && m_busy(f, in_rt));
   endfunction

   function automatic logic [31:0] m_busy_vec(int f);
      logic [31:0] b = '0;
      for (int r = 0; r < 32; r++) b[r] = m_busy(f, r);
      return b;
   endfunction

   task automatic model_clear();
      for (int f = 0; f < 2; f++) begin
         for (int r = 0; r < 32; r++) rdy[f][r] = 0;
         sc[f] = 0;
      end
   endtask

   task automatic model_edge();
      for (int f = 0; f < 2; f++) begin
         bit st, is;
         int lat;
         st = in_valid && !in_fl && m_haz(f);
         is = in_valid && !in_fl && !m_haz(f);
         if (st) sc[f]++;
         lat = (f == 0) ? 3 : (in_ld ? 1 : 0);
         if (is && in_we && in_rd != 0 && lat > 0 && rdy[f][in_rd] < cyc + lat + 1)
            rdy[f][in_rd] = cyc + lat + 1;
      end
      cyc++;
   endtask

   task automatic model_compare();
      chk("rnd_stall0", if0.stall, in_valid && !in_fl && m_haz(0));
      chk("rnd_issue0", if0.issue, in_valid && !in_fl && !m_haz(0));
      chk("rnd_busy0", if0.busy_vec, m_busy_vec(0));
      chk("rnd_cnt0", if0.stall_cnt, (sc[0] > 65535) ? 65535 : sc[0]);
      chk("rnd_stall1", if1.stall, in_valid && !in_fl && m_haz(1));
      chk("rnd_issue1", if1.issue, in_valid && !in_fl && !m_haz(1));
      chk("rnd_busy1", if1.busy_vec, m_busy_vec(1));
      chk("rnd_cnt1", if1.stall_cnt, (sc[1] > 65535) ? 65535 : sc[1]);
      chk("rnd_cnt_sat", if2.stall_cnt, (sc[0] > 15) ? 15 : sc[0]);
   endtask

   task automatic set_in(input bit v, input int rs, input int rt, input bit rsu, input bit rtu,
                         input int rd, input bit we, input bit ld, input bit fl);
      in_valid = v;  in_rs = rs[4:0];  in_rt = rt[4:0];  in_rsu = rsu;  in_rtu = rtu;
      in_rd = rd[4:0];  in_we = we;  in_ld = ld;  in_fl = fl;
   endtask

   task automatic tick();
      model_edge();
      @(posedge clk1);
      #1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      #1;
      chk("rst_stall", if0.stall, 1'b0);
      chk("rst_busy", if0.busy_vec, '0);
      chk("rst_cnt", if0.stall_cnt, '0);
      model_clear();
      @(posedge clk1);
      #1;
      rst_n = 1'b1;
   endtask

   // Holds one instruction in ID until build sel issues it; returns the stall cycles seen.
   task automatic run_instr(input int sel, input int rs, input int rt, input bit rsu, input bit rtu,
                            input int rd, input bit we, input bit ld, output int stalls);
      bit done = 1'b0;
      stalls = 0;
      set_in(1'b1, rs, rt, rsu, rtu, rd, we, ld, 1'b0);
      for (int k = 0; k < 20 && !done; k++) begin
         @(negedge clk1);
         if ((sel == 0) ? if0.stall : if1.stall) stalls++;
         done = (sel == 0) ? if0.issue : if1.issue;
         tick();
      end
      chk("issue_within_bound", done, 1'b1);
      set_in(1'b0, 0, 0, 1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b0);
   endtask

   typedef struct {
      bit rst; bit v; bit [4:0] rs; bit [4:0] rt; bit rsu; bit rtu; bit [4:0] rd;
      bit we; bit ld; bit fl; bit st; bit is; int sc; bit [31:0] busy;
   } vec_t;

   function automatic vec_t mk(bit rst, bit v, int rs, int rt, bit rsu, bit rtu, int rd,
                               bit we, bit ld, bit fl, bit st, bit is, int sc, logic [31:0] busy);
      vec_t x;
      x.rst = rst; x.v = v; x.rs = rs[4:0]; x.rt = rt[4:0]; x.rsu = rsu; x.rtu = rtu;
      x.rd = rd[4:0]; x.we = we; x.ld = ld; x.fl = fl; x.st = st; x.is = is; x.sc = sc; x.busy = busy;
      return x;
   endfunction

   vec_t tbl [$];

   initial begin
      int s;
      rst_n = 1'b0;
      set_in(1'b1, 1, 0, 1'b1, 1'b0, 2, 1'b1, 1'b0, 1'b0);
      #1;
      chk("reset_stall", if0.stall, 1'b0);
      chk("reset_issue", if0.issue, 1'b1);
      chk("reset_busy", if0.busy_vec, '0);
      chk("reset_cnt", if0.stall_cnt, '0);
      @(posedge clk1);
      #1;
      rst_n = 1'b1;

      // ADDI R1,R0,10 ; ADD R4,R1,R2
      tbl.push_back(mk(1, 1, 0, 0, 1, 0, 1, 1, 0, 0, 0, 1, 0, 32'h0));
      tbl.push_back(mk(0, 1, 1, 2, 1, 1, 4, 1, 0, 0, 1, 0, 0, 32'h2));
      tbl.push_back(mk(0, 1, 1, 2, 1, 1, 4, 1, 0, 0, 1, 0, 1, 32'h2));
      tbl.push_back(mk(0, 1, 1, 2, 1, 1, 4, 1, 0, 0, 1, 0, 2, 32'h2));
      tbl.push_back(mk(0, 1, 1, 2, 1, 1, 4, 1, 0, 0, 0, 1, 3, 32'h0));
      tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 3, 32'h10));
      // ADDI R1 ; ADDI R2 ; ADDI R3 ; ADD R4,R1,R2 ; ADD R5,R4,R3
      tbl.push_back(mk(1, 1, 0, 0, 1, 0, 1, 1, 0, 0, 0, 1, 0, 32'h0));
      tbl.push_back(mk(0, 1, 0, 0, 1, 0, 2, 1, 0, 0, 0, 1, 0, 32'h2));
      tbl.push_back(mk(0, 1, 0, 0, 1, 0, 3, 1, 0, 0, 0, 1, 0, 32'h6));
      tbl.push_back(mk(0, 1, 1, 2, 1, 1, 4, 1, 0, 0, 1, 0, 0, 32'hE));
      tbl.push_back(mk(0, 1, 1, 2, 1, 1, 4, 1, 0, 0, 1, 0, 1, 32'hC));
      tbl.push_back(mk(0, 1, 1, 2, 1, 1, 4, 1, 0, 0, 0, 1, 2, 32'h8));
      tbl.push_back(mk(0, 1, 4, 3, 1, 1, 5, 1, 0, 0, 1, 0, 2, 32'h10));
      tbl.push_back(mk(0, 1, 4, 3, 1, 1, 5, 1, 0, 0, 1, 0, 3, 32'h10));
      tbl.push_back(mk(0, 1, 4, 3, 1, 1, 5, 1, 0, 0, 1, 0, 4, 32'h10));
      tbl.push_back(mk(0, 1, 4, 3, 1, 1, 5, 1, 0, 0, 0, 1, 5, 32'h0));
      tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 5, 32'h20));
      // ADDI R0,R0,5 ; ADD R9,R0,R0
      tbl.push_back(mk(1, 1, 0, 0, 1, 0, 0, 1, 0, 0, 0, 1, 0, 32'h0));
      tbl.push_back(mk(0, 1, 0, 0, 1, 1, 9, 1, 0, 0, 0, 1, 0, 32'h0));
      tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h200));

      foreach (tbl[i]) begin
         if (tbl[i].rst) do_reset();
         set_in(tbl[i].v, tbl[i].rs, tbl[i].rt, tbl[i].rsu, tbl[i].rtu, tbl[i].rd,
                tbl[i].we, tbl[i].ld, tbl[i].fl);
         @(negedge clk1);
         chk($sformatf("tbl%0d_stall", i), if0.stall, tbl[i].st);
         chk($sformatf("tbl%0d_issue", i), if0.issue, tbl[i].is);
         chk($sformatf("tbl%0d_stall_cnt", i), if0.stall_cnt, tbl[i].sc);
         chk($sformatf("tbl%0d_busy", i), if0.busy_vec, tbl[i].busy);
         tick();
      end

      // Forwarding build: LW R6 ; ADD R7,R6,R1 ; ADD R8,R7,R1
      do_reset();
      run_instr(1, 0, 0, 1'b1, 1'b0, 6, 1'b1, 1'b1, s);
      chk("fwd_lw_stalls", s, 0);
      run_instr(1, 6, 1, 1'b1, 1'b1, 7, 1'b1, 1'b0, s);
      chk("fwd_load_use_stalls", s, 1);
      run_instr(1, 7, 1, 1'b1, 1'b1, 8, 1'b1, 1'b0, s);
      chk("fwd_alu_dep_stalls", s, 0);
      chk("fwd_stall_cnt", if1.stall_cnt, 1);

      // Flush while a dependent instruction is stalled
      do_reset();
      run_instr(0, 0, 0, 1'b1, 1'b0, 1, 1'b1, 1'b0, s);
      set_in(1'b1, 1, 2, 1'b1, 1'b1, 4, 1'b1, 1'b0, 1'b0);
      @(negedge clk1);
      chk("flush_pre_stall", if0.stall, 1'b1);
      tick();
      set_in(1'b1, 1, 2, 1'b1, 1'b1, 4, 1'b1, 1'b0, 1'b1);
      @(negedge clk1);
      chk("flush_stall", if0.stall, 1'b0);
      chk("flush_issue", if0.issue, 1'b0);
      tick();
      set_in(1'b0, 0, 0, 1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b0);
      @(negedge clk1);
      chk("flush_busy_after", if0.busy_vec, 32'h2);
      tick();
      @(negedge clk1);
      chk("flush_busy_drained", if0.busy_vec, 32'h0);
      chk("flush_stall_cnt", if0.stall_cnt, 1);
      tick();

      // Long dependent chain saturates the 4-bit statistics counter
      do_reset();
      run_instr(0, 0, 0, 1'b1, 1'b0, 1, 1'b1, 1'b0, s);
      for (int k = 0; k < 8; k++) begin
         run_instr(0, 1, 0, 1'b1, 1'b1, 1, 1'b1, 1'b0, s);
         chk($sformatf("chain%0d_stalls", k), s, 3);
      end
      chk("sat_stall_cnt", if2.stall_cnt, 15);
      chk("wide_stall_cnt", if0.stall_cnt, 24);

      // Randomized traffic against the timestamp model, with occasional mid-run resets
      do_reset();
      for (int k = 0; k < 800; k++) begin
         if ($urandom_range(0, 149) == 0) do_reset();
         set_in($urandom_range(0, 99) < 85, $urandom_range(0, 7), $urandom_range(0, 7),
                $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 7),
                $urandom_range(0, 99) < 70, $urandom_range(0, 99) < 40,
                $urandom_range(0, 99) < 10);
         @(negedge clk1);
         model_compare();
         tick();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end
endmodule
